// File: rtl/rst_seq_gen.sv
// Staged per-domain reset sequencer with software/watchdog re-reset and recorded cause.
// Define RST_SEQ_WDT_EN to make WDT_RST_REQ a re-reset source; otherwise it is ignored.
`timescale 1ns/1ps
module rst_seq_gen #(
  parameter int NUM_DOMAINS  = 4,
  parameter int STAGE_CYCLES = 16,
  parameter int HOLD_CYCLES  = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 8
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   SW_RST_REQ,
  input  logic                   WDT_RST_REQ,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RSTN,
  output logic                   RST_DONE,
  output logic [1:0]             RST_CAUSE
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] STAGE_END = CNT_W'(STAGE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(HOLD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN,
    ST_HOLD
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [IDX_W-1:0]         idx;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     rsync;
  logic                     wdt_req;
  logic [CNT_W-1:0]         cnt_inc;
  logic [NUM_DOMAINS-1:0]   idx_onehot;

`ifdef RST_SEQ_WDT_EN
  assign wdt_req = WDT_RST_REQ;
`else
  logic unused_wdt;
  assign unused_wdt = WDT_RST_REQ;
  assign wdt_req    = 1'b0;
`endif

  // NOTE: assertion clears the chain asynchronously; only the release edge is synchronised.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rsync      = sync_q[SYNC_STAGES-1];
  assign cnt_inc    = cnt + CNT_W'(1);
  assign idx_onehot = NUM_DOMAINS'(1) << idx;

  // The edge on which ASSERT first sees rsync already counts as the first
  // stage cycle, so a stage of one cycle releases domain 0 on that very edge.
  // NOTE: all state and outputs use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      idx         <= '0;
      DOMAIN_RSTN <= '0;
      RST_DONE    <= 1'b0;
      RST_CAUSE   <= CAUSE_POR;
    end else begin
      case (state)
        ST_ASSERT, ST_RELEASE: begin
          if (state == ST_RELEASE || rsync) begin
            if (cnt_inc == STAGE_END) begin
              DOMAIN_RSTN <= DOMAIN_RSTN | idx_onehot;
              cnt         <= '0;
              if (idx == IDX_LAST) begin
                idx      <= '0;
                RST_DONE <= 1'b1;
                state    <= ST_RUN;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= ST_RELEASE;
              end
            end else begin
              cnt   <= cnt_inc;
              state <= ST_RELEASE;
            end
          end
        end
        ST_RUN: begin
          if (wdt_req || SW_RST_REQ) begin
            DOMAIN_RSTN <= '0;
            RST_DONE    <= 1'b0;
            RST_CAUSE   <= wdt_req ? CAUSE_WDT : CAUSE_SW;
            cnt         <= '0;
            idx         <= '0;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_inc == HOLD_END) begin
            cnt   <= '0;
            state <= ST_RELEASE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= ST_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench for rst_seq_gen: expected output snapshots are queued per
// stimulus and compared 1 ns after the scheduled clock edge.
`timescale 1ns/1ps
module tb_rst_seq_gen;

`ifdef RST_SEQ_WDT_EN
  localparam logic [1:0] BOTH_CAUSE = 2'b10;
`else
  localparam logic [1:0] BOTH_CAUSE = 2'b01;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sw_req = 1'b0;
  logic       wdt_req = 1'b0;
  logic       alt_req = 1'b0;
  logic [3:0] dom;
  logic       done;
  logic [1:0] cause;
  logic       alt_dom;
  logic       alt_done;
  logic [1:0] alt_cause;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int ref_edge = 0;

  typedef struct {
    int         at;
    logic [3:0] dom;
    logic       done;
    logic [1:0] cause;
    bit         chk_alt;
    logic       alt_dom;
    logic       alt_done;
  } exp_t;

  exp_t sb[$];

  always #12.5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rst_seq_gen u_dut (
    .CLK         (clk),
    .RSTN        (rstn),
    .SW_RST_REQ  (sw_req),
    .WDT_RST_REQ (wdt_req),
    .DOMAIN_RSTN (dom),
    .RST_DONE    (done),
    .RST_CAUSE   (cause)
  );

  rst_seq_gen #(.NUM_DOMAINS(1), .STAGE_CYCLES(1), .SYNC_STAGES(2)) u_alt (
    .CLK         (clk),
    .RSTN        (rstn),
    .SW_RST_REQ  (alt_req),
    .WDT_RST_REQ (alt_req),
    .DOMAIN_RSTN (alt_dom),
    .RST_DONE    (alt_done),
    .RST_CAUSE   (alt_cause)
  );

  task automatic push_exp(input int at, input logic [3:0] d, input logic dn,
                          input logic [1:0] c);
    sb.push_back('{at, d, dn, c, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic push_alt(input int at, input logic [3:0] d, input logic dn,
                          input logic [1:0] c, input logic ad, input logic adn);
    sb.push_back('{at, d, dn, c, 1'b1, ad, adn});
  endtask

  // Waits until edge 'target' has happened, then steps 1 ns off the edge.
  task automatic wait_cyc(input int target);
    if (target < cyc) begin
      n_checks++;
      $display("FAIL schedule: edge %0d already passed (now %0d)", target, cyc);
    end else begin
      wait (cyc >= target);
    end
    #1;
  endtask

  task automatic sb_drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_cyc(e.at);
      n_checks++;
      if ({dom, done, cause} !== {e.dom, e.done, e.cause})
        $display("FAIL %s edge+%0d: dom=%b done=%b cause=%b, expected dom=%b done=%b cause=%b",
                 tag, e.at - ref_edge, dom, done, cause, e.dom, e.done, e.cause);
      else
        n_pass++;
      if (e.chk_alt) begin
        n_checks++;
        if ({alt_dom, alt_done, alt_cause} !== {e.alt_dom, e.alt_done, 2'b00})
          $display("FAIL %s_alt edge+%0d: dom=%b done=%b cause=%b, expected dom=%b done=%b cause=00",
                   tag, e.at - ref_edge, alt_dom, alt_done, alt_cause, e.alt_dom, e.alt_done);
        else
          n_pass++;
      end
    end
  endtask

  // Drives the request lines so the DUT samples them on edge 'at' only.
  task automatic pulse(input int at, input logic s, input logic w);
    wait_cyc(at - 1);
    sw_req  = s;
    wdt_req = w;
    wait_cyc(at);
    sw_req  = 1'b0;
    wdt_req = 1'b0;
  endtask

  task automatic push_power_on(input int b);
    push_alt(b + 2,  4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);
    push_alt(b + 3,  4'b0000, 1'b0, 2'b00, 1'b1, 1'b1);
    push_alt(b + 17, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b1);
    push_alt(b + 18, 4'b0001, 1'b0, 2'b00, 1'b1, 1'b1);
    push_alt(b + 33, 4'b0001, 1'b0, 2'b00, 1'b1, 1'b1);
    push_alt(b + 34, 4'b0011, 1'b0, 2'b00, 1'b1, 1'b1);
    push_alt(b + 49, 4'b0011, 1'b0, 2'b00, 1'b1, 1'b1);
    push_alt(b + 50, 4'b0111, 1'b0, 2'b00, 1'b1, 1'b1);
    push_alt(b + 65, 4'b0111, 1'b0, 2'b00, 1'b1, 1'b1);
    push_alt(b + 66, 4'b1111, 1'b1, 2'b00, 1'b1, 1'b1);
  endtask

  // Expected snapshots around a re-reset sampled at edge k.
  task automatic push_rereset(input int k, input logic [1:0] prev, input logic [1:0] c);
    push_exp(k - 1,  4'b1111, 1'b1, prev);
    push_exp(k,      4'b0000, 1'b0, c);
    push_exp(k + 23, 4'b0000, 1'b0, c);
    push_exp(k + 24, 4'b0001, 1'b0, c);
    push_exp(k + 40, 4'b0011, 1'b0, c);
    push_exp(k + 56, 4'b0111, 1'b0, c);
    push_exp(k + 71, 4'b0111, 1'b0, c);
    push_exp(k + 72, 4'b1111, 1'b1, c);
  endtask

  task automatic test_reset();
    sw_req = 1'b1;
    wait_cyc(3);
    n_checks++;
    if ({dom, done, cause, alt_dom, alt_done, alt_cause} !== 11'b0)
      $display("FAIL reset_values: dom=%b done=%b cause=%b alt=%b/%b, expected all zero",
               dom, done, cause, alt_dom, alt_done);
    else
      n_pass++;
    sw_req = 1'b0;
  endtask

  // Power-on release at 500 ns, with a software request during RELEASE that must be ignored.
  task automatic test_power_on();
    wait_cyc(20);
    #11.5;
    rstn     = 1'b1;
    ref_edge = cyc;
    push_power_on(ref_edge);
    fork
      sb_drain("power_on");
      pulse(ref_edge + 40, 1'b1, 1'b0);
    join
  endtask

  task automatic test_sw_reset();
    int k;
    k        = ref_edge + 90;
    ref_edge = k;
    push_rereset(k, 2'b00, 2'b01);
    fork
      sb_drain("sw_reset");
      pulse(k, 1'b1, 1'b0);
    join
  endtask

  task automatic test_simultaneous();
    int k;
    k        = ref_edge + 90;
    ref_edge = k;
    push_rereset(k, 2'b01, BOTH_CAUSE);
    fork
      sb_drain("simultaneous");
      pulse(k, 1'b1, 1'b1);
    join
  endtask

  task automatic test_wdt_alone();
    int k;
    k        = ref_edge + 90;
    ref_edge = k;
`ifdef RST_SEQ_WDT_EN
    push_rereset(k, BOTH_CAUSE, 2'b10);
`else
    push_exp(k,      4'b1111, 1'b1, BOTH_CAUSE);
    push_exp(k + 1,  4'b1111, 1'b1, BOTH_CAUSE);
    push_exp(k + 24, 4'b1111, 1'b1, BOTH_CAUSE);
`endif
    fork
      sb_drain("wdt_alone");
      pulse(k, 1'b0, 1'b1);
    join
  endtask

  task automatic test_rstn_mid();
    int k;
    k        = ref_edge + 90;
    ref_edge = k;
    push_exp(k,      4'b0000, 1'b0, 2'b01);
    push_exp(k + 24, 4'b0001, 1'b0, 2'b01);
    push_exp(k + 45, 4'b0011, 1'b0, 2'b01);
    fork
      sb_drain("pre_rstn_drop");
      pulse(k, 1'b1, 1'b0);
    join
    #4;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({dom, done, cause, alt_dom, alt_done} !== 9'b0)
      $display("FAIL rstn_async: dom=%b done=%b cause=%b alt=%b/%b, expected all zero",
               dom, done, cause, alt_dom, alt_done);
    else
      n_pass++;
    wait_cyc(cyc + 3);
    #10;
    rstn     = 1'b1;
    ref_edge = cyc;
    push_power_on(ref_edge);
    sb_drain("restart");
  endtask

  initial begin
    #100us;
    $display("FAIL timeout: bench did not finish, %0d checks made", n_checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_power_on();
    test_sw_reset();
    test_simultaneous();
    test_wdt_alone();
    test_rstn_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
